// File: rtl/wb_chk_pkg.sv
// Shared definitions for the Wishbone burst checker.
//   state_t      : run FSM states
//   PAT_*        : pat_sel encodings
//   CTI_*        : Wishbone cycle type identifiers
//   lfsr_taps()  : right-shifting Galois LFSR feedback mask per data width
package wb_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_INIT,
    ST_WR,
    ST_GAP,
    ST_RD,
    ST_DONE
  } state_t;

  localparam logic [1:0] PAT_ADDR  = 2'd0;
  localparam logic [1:0] PAT_WALK  = 2'd1;
  localparam logic [1:0] PAT_LFSR  = 2'd2;
  localparam logic [1:0] PAT_CONST = 2'd3;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Maximal-length masks for the common widths. Any other width falls back
  // to a top-bit-only mask: still a deterministic sequence, just not maximal.
  function automatic logic [63:0] lfsr_taps(input int w);
    case (w)
      8:       lfsr_taps = 64'h0000_0000_0000_00B8;
      16:      lfsr_taps = 64'h0000_0000_0000_B400;
      32:      lfsr_taps = 64'h0000_0000_B4BC_D35C;
      64:      lfsr_taps = 64'hD800_0000_0000_0000;
      default: lfsr_taps = (w <= 64) ? (64'h1 << (w - 1)) : 64'h0;
    endcase
  endfunction

endpackage

// File: rtl/wb_pat_gen.sv
// Per-beat data pattern generator.
//   clk/rst_n : clock, synchronous active-low reset
//   pat_sel   : pattern selection (PAT_*)
//   seed      : LFSR seed / constant value
//   beat      : current beat index within the phase
//   addr      : current beat byte address
//   restart   : reload the LFSR from seed (zero seed replaced by 1)
//   step      : advance the LFSR one step (once per accepted beat)
//   data      : pattern value for the current beat
module wb_pat_gen
  import wb_chk_pkg::*;
#(
  parameter int APP_AW = 26,
  parameter int dw     = 32,
  parameter int bl     = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        pat_sel,
  input  logic [dw-1:0]     seed,
  input  logic [bl-1:0]     beat,
  input  logic [APP_AW-1:0] addr,
  input  logic              restart,
  input  logic              step,
  output logic [dw-1:0]     data
);

  localparam logic [dw-1:0] TAPS = dw'(lfsr_taps(dw));

  logic [dw-1:0] lfsr;
  logic [dw-1:0] seed_nz;
  logic [31:0]   walk_idx;

  // An all-zero state would lock the LFSR up, so a zero seed becomes 1.
  assign seed_nz  = (seed == '0) ? dw'(1) : seed;
  assign walk_idx = 32'(beat) % 32'(dw);

  always_ff @(posedge clk) begin
    if (!rst_n)       lfsr <= '0;
    else if (restart) lfsr <= seed_nz;
    else if (step)    lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
  end

  always_comb begin
    data = '0;
    case (pat_sel)
      PAT_ADDR:  data = dw'(addr);
      PAT_WALK:  data = dw'(1) << walk_idx;
      PAT_LFSR:  data = lfsr;
      PAT_CONST: data = seed;
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/wb_burst_checker.sv
// Wishbone B3 burst master with readback compare. Each accepted start writes
// burst_len beats of generated data, leaves one idle cycle, reads the same
// range back and compares every beat against the regenerated pattern.
//   wb_clk_i, RESETN          : clock, synchronous active-low reset
//   sdr_init_done             : traffic held off until SDRAM is initialised
//   start/start_addr/burst_len/pat_sel/pat_seed : run request (latched)
//   busy/done/timeout         : run status (done is a 1-cycle pulse)
//   err_cnt/first_err_*       : saturating mismatch count, first bad address
//   wb_*                      : Wishbone master port
module wb_burst_checker
  import wb_chk_pkg::*;
#(
  parameter int APP_AW  = 26,
  parameter int dw      = 32,
  parameter int bl      = 9,
  parameter int TIMEOUT = 1024
) (
  input  logic              wb_clk_i,
  input  logic              RESETN,
  input  logic              sdr_init_done,
  input  logic              start,
  input  logic [APP_AW-1:0] start_addr,
  input  logic [bl-1:0]     burst_len,
  input  logic [1:0]        pat_sel,
  input  logic [dw-1:0]     pat_seed,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       err_cnt,
  output logic [APP_AW-1:0] first_err_addr,
  output logic              first_err_vld,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [dw-1:0]     wb_dat_o,
  output logic [dw/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [dw-1:0]     wb_dat_i
);

  localparam int BYTES = dw / 8;
  localparam int WDW   = $clog2(TIMEOUT + 1);
  localparam logic [APP_AW-1:0] ADDR_STEP  = APP_AW'(BYTES);
  localparam logic [APP_AW-1:0] ALIGN_MASK = ~APP_AW'(BYTES - 1);
  localparam logic [WDW-1:0]    WD_LAST    = WDW'(TIMEOUT - 1);

  state_t state, state_nxt;

  logic [bl-1:0]     len_r;
  logic [1:0]        pat_sel_r;
  logic [dw-1:0]     seed_r;
  logic [APP_AW-1:0] base_addr_r;
  logic [APP_AW-1:0] addr_r;
  logic [bl-1:0]     beat_r;
  logic [WDW-1:0]    wd_r;

  logic          in_bus, ack, last_beat, wd_expired, accept, pat_restart;
  logic [dw-1:0] pat_data;

  assign in_bus      = (state == ST_WR) || (state == ST_RD);
  // Acks outside an active strobe are ignored.
  assign ack         = in_bus && wb_ack_i;
  assign last_beat   = (beat_r == len_r - 1'b1);
  assign wd_expired  = in_bus && !wb_ack_i && (wd_r == WD_LAST);
  assign accept      = (state == ST_IDLE) && start;
  // Reload the LFSR ahead of each phase so RD regenerates the WR sequence.
  assign pat_restart = (state == ST_WAIT_INIT) || (state == ST_GAP);

  wb_pat_gen #(
    .APP_AW (APP_AW),
    .dw     (dw),
    .bl     (bl)
  ) u_pat_gen (
    .clk     (wb_clk_i),
    .rst_n   (RESETN),
    .pat_sel (pat_sel_r),
    .seed    (seed_r),
    .beat    (beat_r),
    .addr    (addr_r),
    .restart (pat_restart),
    .step    (ack),
    .data    (pat_data)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!RESETN) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wb_cyc_o  = in_bus;
    wb_stb_o  = in_bus;
    wb_we_o   = (state == ST_WR);
    wb_addr_o = addr_r;
    wb_dat_o  = (state == ST_WR) ? pat_data : '0;
    wb_sel_o  = '1;
    wb_cti_o  = CTI_CLASSIC;
    if (in_bus && (len_r != bl'(1)))
      wb_cti_o = last_beat ? CTI_EOB : CTI_INCR;

    case (state)
      ST_IDLE:      if (start) state_nxt = (burst_len == '0) ? ST_DONE : ST_WAIT_INIT;
      ST_WAIT_INIT: if (sdr_init_done) state_nxt = ST_WR;
      ST_WR: begin
        if (ack && last_beat) state_nxt = ST_GAP;
        else if (wd_expired)  state_nxt = ST_DONE;
      end
      ST_GAP:       state_nxt = ST_RD;
      ST_RD: begin
        if (ack && last_beat) state_nxt = ST_DONE;
        else if (wd_expired)  state_nxt = ST_DONE;
      end
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!RESETN) begin
      len_r          <= '0;
      pat_sel_r      <= '0;
      seed_r         <= '0;
      base_addr_r    <= '0;
      addr_r         <= '0;
      beat_r         <= '0;
      wd_r           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_vld  <= 1'b0;
    end else begin
      done <= (state == ST_DONE);

      if (accept) begin
        len_r          <= burst_len;
        pat_sel_r      <= pat_sel;
        seed_r         <= pat_seed;
        base_addr_r    <= start_addr & ALIGN_MASK;
        addr_r         <= start_addr & ALIGN_MASK;
        beat_r         <= '0;
        wd_r           <= '0;
        busy           <= 1'b1;
        timeout        <= 1'b0;
        err_cnt        <= '0;
        first_err_addr <= '0;
        first_err_vld  <= 1'b0;
      end

      if (state == ST_DONE) busy <= 1'b0;

      // Beat/address advance and ack watchdog.
      if (ack) begin
        beat_r <= beat_r + 1'b1;
        addr_r <= addr_r + ADDR_STEP;
        wd_r   <= '0;
      end else if (in_bus) begin
        wd_r   <= wd_r + 1'b1;
      end

      if (state == ST_GAP) begin
        beat_r <= '0;
        addr_r <= base_addr_r;
        wd_r   <= '0;
      end

      if (wd_expired) timeout <= 1'b1;

      if ((state == ST_RD) && ack && (wb_dat_i != pat_data)) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 32'd1;
        if (!first_err_vld) begin
          first_err_addr <= addr_r;
          first_err_vld  <= 1'b1;
        end
      end
    end
  end

endmodule
